// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one memory request in flight,
// and presents fetched words to decode through a registered slot backed by a 1-entry skid.
module pipeline_fetch #(
  parameter int                       ADDR_WIDTH = 64,
  parameter int                       DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0,
  parameter logic [DATA_WIDTH/2-1:0]  BUBBLE     = (DATA_WIDTH/2)'(32'd90)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [ADDR_WIDTH-1:0]     imem_req_addr,
  input  logic                      imem_resp_valid,
  input  logic [DATA_WIDTH/2-1:0]   imem_resp_data,
  input  logic                      decode_ready,
  output logic [DATA_WIDTH/2-1:0]   instruction,
  output logic [ADDR_WIDTH-1:0]     instruction_pc
);

  localparam int IW = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nx;
  logic [ADDR_WIDTH-1:0] req_pc, req_pc_nx;
  logic                  drop, drop_nx;
  logic                  slot_valid, slot_valid_nx;
  logic [IW-1:0]         slot_instr, slot_instr_nx;
  logic [ADDR_WIDTH-1:0] slot_pc, slot_pc_nx;
  logic                  skid_valid, skid_valid_nx;
  logic [IW-1:0]         skid_instr, skid_instr_nx;
  logic [ADDR_WIDTH-1:0] skid_pc, skid_pc_nx;
  logic                  accept;
  logic                  load_resp;
  logic                  load_skid;

  // Request and slot outputs come straight from state registers.
  assign imem_req_valid = (state == ST_ISSUE);
  assign imem_req_addr  = fetch_pc;
  assign instruction    = slot_instr;
  assign instruction_pc = slot_pc;

  // Next-state, PC bookkeeping and slot/skid movement.
  always_comb begin
    state_nx      = state;
    fetch_pc_nx   = fetch_pc;
    req_pc_nx     = req_pc;
    drop_nx       = drop;
    slot_valid_nx = slot_valid;
    slot_instr_nx = slot_instr;
    slot_pc_nx    = slot_pc;
    skid_valid_nx = skid_valid;
    skid_instr_nx = skid_instr;
    skid_pc_nx    = skid_pc;
    load_resp     = 1'b0;
    load_skid     = 1'b0;
    accept        = (state == ST_ISSUE) && imem_req_ready;

    case (state)
      ST_RST: begin
        state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (accept) begin
          req_pc_nx   = fetch_pc;
          fetch_pc_nx = fetch_pc + ADDR_WIDTH'(3'd4);
          state_nx    = ST_WAIT;
        end else begin
          state_nx = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (!imem_resp_valid) begin
          state_nx = ST_WAIT;
        end else if (drop) begin
          drop_nx  = 1'b0;
          state_nx = ST_ISSUE;
        end else if (!slot_valid || decode_ready) begin
          load_resp = 1'b1;
          state_nx  = ST_ISSUE;
        end else begin
          skid_valid_nx = 1'b1;
          skid_instr_nx = imem_resp_data;
          skid_pc_nx    = req_pc;
          state_nx      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (decode_ready) begin
          load_skid     = 1'b1;
          skid_valid_nx = 1'b0;
          state_nx      = ST_ISSUE;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_RST;
      end
    endcase

    // An empty slot always reads as BUBBLE/0 so the outputs need no extra muxing.
    if (load_resp) begin
      slot_valid_nx = 1'b1;
      slot_instr_nx = imem_resp_data;
      slot_pc_nx    = req_pc;
    end else if (load_skid) begin
      slot_valid_nx = 1'b1;
      slot_instr_nx = skid_instr;
      slot_pc_nx    = skid_pc;
    end else if (decode_ready) begin
      slot_valid_nx = 1'b0;
      slot_instr_nx = BUBBLE;
      slot_pc_nx    = '0;
    end else begin
      slot_valid_nx = slot_valid;
    end

    // Redirect overrides everything above; an already-accepted request becomes stale.
    if (redirect_valid && (state != ST_RST)) begin
      fetch_pc_nx   = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      slot_valid_nx = 1'b0;
      slot_instr_nx = BUBBLE;
      slot_pc_nx    = '0;
      skid_valid_nx = 1'b0;
      case (state)
        ST_ISSUE: begin
          if (accept) begin
            drop_nx  = 1'b1;
            state_nx = ST_WAIT;
          end else begin
            state_nx = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            drop_nx  = 1'b0;
            state_nx = ST_ISSUE;
          end else begin
            drop_nx  = 1'b1;
            state_nx = ST_WAIT;
          end
        end
        ST_HOLD: begin
          state_nx = ST_ISSUE;
        end
        default: begin
          state_nx = ST_ISSUE;
        end
      endcase
    end else begin
      drop_nx = drop_nx;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RST;
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      drop       <= 1'b0;
      slot_valid <= 1'b0;
      slot_instr <= BUBBLE;
      slot_pc    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state      <= state_nx;
      fetch_pc   <= fetch_pc_nx;
      req_pc     <= req_pc_nx;
      drop       <= drop_nx;
      slot_valid <= slot_valid_nx;
      slot_instr <= slot_instr_nx;
      slot_pc    <= slot_pc_nx;
      skid_valid <= skid_valid_nx;
      skid_instr <= skid_instr_nx;
      skid_pc    <= skid_pc_nx;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Self-checking bench for pipeline_fetch: behavioural memory with variable latency,
// scoreboard of expected deliveries, redirect table and hand-written corner sequences.
module tb_pipeline_fetch;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 32;
  localparam logic [IW-1:0] BUB = 32'd90;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid = 1'b0;
  logic [IW-1:0] imem_resp_data = '0;
  logic          decode_ready = 1'b0;
  logic [IW-1:0] instruction;
  logic [AW-1:0] instruction_pc;

  pipeline_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(64'h0), .BUBBLE(32'd90)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .decode_ready(decode_ready), .instruction(instruction), .instruction_pc(instruction_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] ins;
    logic [AW-1:0] pc;
  } entry_t;

  typedef struct {
    logic [AW-1:0] target;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_second;
  } redir_vec_t;

  entry_t        sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            pend = 1'b0;
  int            pend_cnt = 0;
  logic [AW-1:0] pend_addr = '0;
  bit            pend_stale = 1'b0;
  logic [AW-1:0] resp_addr = '0;
  bit            resp_stale = 1'b0;
  int            mem_lat = 1;
  logic [AW-1:0] exp_fetch = '0;
  bit            acc_seen = 1'b0;
  logic [AW-1:0] acc_last = '0;

  function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
    if (a == 64'h0) return 32'h0000_0013;
    else if (a == 64'h4) return 32'h0010_0093;
    else return a[31:0] ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    pend = 1'b0;
    resp_stale = 1'b0;
    imem_resp_valid = 1'b0;
    exp_fetch = 64'h0;
  endtask

  // One clock: score the current cycle, advance, then model the memory response.
  task automatic tick();
    logic   acc;
    logic   cons;
    logic   resp_now;
    entry_t e;
    acc = imem_req_valid && imem_req_ready && !reset;
    resp_now = imem_resp_valid;
    cons = decode_ready && !reset && !((instruction == BUB) && (instruction_pc == 64'h0));
    if (acc) begin
      chk("req_addr", imem_req_addr, exp_fetch);
      acc_seen = 1'b1;
      acc_last = imem_req_addr;
    end
    if (redirect_valid && !reset) begin
      sb.delete();
      if (pend) pend_stale = 1'b1;
      exp_fetch = {redirect_pc[AW-1:2], 2'b00};
    end else begin
      if (cons) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got %h at pc %h expected none", instruction, instruction_pc);
        end else begin
          e = sb.pop_front();
          chk("instr", {32'h0, instruction}, {32'h0, e.ins});
          chk("instr_pc", instruction_pc, e.pc);
        end
      end
      if (resp_now && !resp_stale) begin
        e.ins = memf(resp_addr);
        e.pc = resp_addr;
        sb.push_back(e);
      end
      if (acc) exp_fetch = exp_fetch + 64'd4;
    end
    if (acc) begin
      pend = 1'b1;
      pend_cnt = mem_lat;
      pend_addr = imem_req_addr;
      pend_stale = redirect_valid;
    end
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = memf(pend_addr);
        resp_addr = pend_addr;
        resp_stale = pend_stale;
      end
    end
  endtask

  task automatic wait_acc(output logic [AW-1:0] addr);
    int n;
    n = 0;
    acc_seen = 1'b0;
    while (!acc_seen && n < 30) begin
      tick();
      n++;
    end
    if (!acc_seen) begin
      checks++;
      errors++;
      $display("FAIL acc_timeout: got no request expected one within 30 cycles");
    end
    addr = acc_last;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    decode_ready = 1'b1;
    imem_req_ready = 1'b0;
    while ((sb.size() != 0 || pend || imem_resp_valid) && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk(name, 64'(sb.size()), 64'h0);
  endtask

  task automatic apply_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_instr", {32'h0, instruction}, {32'h0, BUB});
    chk("rst_pc", instruction_pc, 64'h0);
    chk("rst_reqv", {63'h0, imem_req_valid}, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk("post_rst_reqv", {63'h0, imem_req_valid}, 64'h1);
    chk("post_rst_addr", imem_req_addr, 64'h0);
  endtask

  redir_vec_t vecs[4];
  logic [AW-1:0] a1, a2, p0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h0000_0000_0000_1003, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1004};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
    vecs[2] = '{64'h0000_0000_0000_0007, 64'h0000_0000_0000_0004, 64'h0000_0000_0000_0008};
    vecs[3] = '{64'h0000_0000_0000_2000, 64'h0000_0000_0000_2000, 64'h0000_0000_0000_2004};

    // Basic fetch with 1-cycle memory and an always-ready decode.
    decode_ready = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    apply_reset();
    tick();
    chk("s1_bubble0", {32'h0, instruction}, {32'h0, BUB});
    tick();
    chk("s1_instr0", {32'h0, instruction}, 64'h13);
    chk("s1_pc0", instruction_pc, 64'h0);
    tick();
    chk("s1_bubble1", {32'h0, instruction}, {32'h0, BUB});
    tick();
    chk("s1_instr1", {32'h0, instruction}, 64'h0010_0093);
    chk("s1_pc1", instruction_pc, 64'h4);

    // Backpressure: slot plus skid fill, then drain in order and resume at 0x8.
    apply_reset();
    decode_ready = 1'b0;
    repeat (6) tick();
    chk("hold_reqv", {63'h0, imem_req_valid}, 64'h0);
    chk("hold_instr", {32'h0, instruction}, 64'h13);
    chk("hold_pc", instruction_pc, 64'h0);
    decode_ready = 1'b1;
    mem_lat = 3;
    wait_acc(a1);
    chk("resume_addr", a1, 64'h8);

    // Redirect while waiting on the 0x8 response.
    redirect_pc = 64'h1000;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("redir_wait_bubble", {32'h0, instruction}, {32'h0, BUB});
    chk("redir_wait_reqv", {63'h0, imem_req_valid}, 64'h0);
    wait_acc(a1);
    chk("redir_wait_addr", a1, 64'h1000);
    mem_lat = 1;
    drain("redir_wait_drain");

    // Redirect in the same cycle as a response.
    imem_req_ready = 1'b1;
    wait_acc(a1);
    chk("resp_now", {63'h0, imem_resp_valid}, 64'h1);
    redirect_pc = 64'h2000;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("redir_resp_reqv", {63'h0, imem_req_valid}, 64'h1);
    wait_acc(a1);
    chk("redir_resp_addr", a1, 64'h2000);
    drain("redir_resp_drain");

    // Redirect target table: alignment and address wrap.
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1;
      decode_ready = 1'b1;
      redirect_pc = vecs[i].target;
      redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      wait_acc(a1);
      wait_acc(a2);
      chk($sformatf("vec%0d_first", i), a1, vecs[i].exp_first);
      chk($sformatf("vec%0d_second", i), a2, vecs[i].exp_second);
    end
    drain("table_drain");

    // Randomised traffic scored entirely by the scoreboard.
    for (int c = 0; c < 400; c++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      decode_ready = ($urandom_range(0, 3) != 0);
      mem_lat = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = {32'h0, $urandom_range(0, 32'hFFFF)};
      tick();
      redirect_valid = 1'b0;
    end
    mem_lat = 1;
    drain("random_drain");

    // Reset while holding a full slot and skid.
    p0 = exp_fetch;
    imem_req_ready = 1'b1;
    decode_ready = 1'b0;
    repeat (8) tick();
    chk("hold2_reqv", {63'h0, imem_req_valid}, 64'h0);
    chk("hold2_pc", instruction_pc, p0);
    apply_reset();
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_fetch.md
Name: pipeline_fetch

Overview:
Instruction-fetch stage. It is the producer end of the decode stage's instruction/instruction_pc/ready interface.
- Maintains the fetch PC and issues requests to the instruction memory port.
- Buffers responses (output slot plus a 1-entry skid) and presents them to decode.
- Presents the bubble encoding 90 when it has no valid instruction.
- Takes PC redirects from execute and discards stale in-flight responses.

Parameters:
ADDR_WIDTH  64  PC / memory address width
DATA_WIDTH  64  datapath width; instruction width is DATA_WIDTH/2
RESET_PC  0  first fetch address after reset
BUBBLE  90  instruction value driven when no valid instruction is present

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  ADDR_WIDTH  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  ADDR_WIDTH  request address
imem_resp_valid  input  1  response data valid (no backpressure; fetch must absorb it)
imem_resp_data  input  DATA_WIDTH/2  fetched instruction word
decode_ready  input  1  decode consumes the presented instruction at this edge
instruction  output  DATA_WIDTH/2  slot instruction, or BUBBLE when the slot is empty
instruction_pc  output  ADDR_WIDTH  PC of the presented instruction; 0 when presenting a bubble

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=RST; fetch_pc=RESET_PC; req_pc=0; slot_valid=0; skid_valid=0; drop=0.
  - Output values during reset: imem_req_valid=0, instruction=BUBBLE, instruction_pc=0.
- Request signals: imem_req_valid=1 only in state ISSUE; imem_req_addr=fetch_pc.
- Outputs: instruction/instruction_pc are driven from registers (slot). No combinational path from imem_resp to decode.
- Slot handshake: the slot is emptied at any edge where decode_ready=1 and it is not reloaded. A bubble is always consumable.
- Request limit: at most one request outstanding.
- One fetch cycle = issue, response, slot visible on the next edge. With 1-cycle memory: request accepted cycle N, response cycle N+1, instruction visible cycle N+2.
- States:
  - RST: on the first edge after reset deasserts -> ISSUE.
  - ISSUE: on imem_req_ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^ADDR_WIDTH), -> WAIT.
  - WAIT: on imem_resp_valid:
    - If drop=1: discard the response, drop<=0, -> ISSUE.
    - Else if slot empty or decode_ready=1: slot<={imem_resp_data, req_pc}, -> ISSUE.
    - Else: skid<={imem_resp_data, req_pc}, -> HOLD.
  - HOLD: no requests. When decode_ready=1: slot<=skid, skid_valid<=0, -> ISSUE.
- imem_resp_valid is ignored in every state other than WAIT.
- Redirect (highest priority, any state except RST):
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - slot_valid<=0, skid_valid<=0, overriding any decode consumption.
  - ISSUE with imem_req_ready=1 in the same cycle: the request is already accepted, so drop<=1, -> WAIT. fetch_pc takes the redirect value, not +4.
  - WAIT without imem_resp_valid: drop<=1, stay WAIT.
  - WAIT with imem_resp_valid in the same cycle: the response is discarded, drop<=0, -> ISSUE.
  - ISSUE without acceptance, or HOLD: -> ISSUE.
- Consecutive redirects: the last one wins. drop never exceeds one because only one request is ever outstanding.
- Reset mid-operation: all state is cleared immediately. The memory is reset by the same signal, so no response from before reset is expected. One arriving in RST or ISSUE is ignored.
- Fetched data equal to BUBBLE is passed through unchanged; decode treats it as a bubble.

Test Plan:
- Reset release, 1-cycle memory, decode_ready=1, memory returns 0x00000013 at 0x0 and 0x00100093 at 0x4 -> imem_req_valid first high the cycle after reset deasserts with addr 0x0. Slot shows 0x00000013/pc 0x0, then 0x00100093/pc 0x4. Bubble (90) shown between them.
- Hold decode_ready=0 while two responses arrive -> first in slot, second in skid, state HOLD, imem_req_valid=0. On decode_ready=1, pc 0x0 then 0x4 are delivered in order and fetch resumes at 0x8.
- Redirect to 0x1000 while in WAIT for 0x8 -> the 0x8 response is dropped and never presented. Next request addr 0x1000. Slot shows bubble until the 0x1000 instruction arrives.
- Redirect to 0x2000 in the same cycle as imem_resp_valid -> that response is discarded, drop stays 0, next request 0x2000.
- Redirect to 0x1003 -> next request addr 0x1000.
- Assert reset while in HOLD with slot and skid full -> outputs go to BUBBLE/0 immediately. After release, first request is addr RESET_PC.
